// File: rtl/ramb16_s2_s2_if.sv
// ---------------------------------------------------------------------------
// ramb16_s2_s2_if
// One access port of the 8192 x 2 dual-port block RAM.
//   addr : 13-bit word address
//   di   : write data
//   we   : write enable, active-high
//   en   : port enable, active-high
//   ssr  : synchronous set/reset of the port output register
//   dout : registered read data
// The master side drives the request fields. The slave side (the RAM)
// drives dout.
// ---------------------------------------------------------------------------
interface ramb16_s2_s2_if;
  logic [12:0] addr;
  logic [1:0]  di;
  logic        we;
  logic        en;
  logic        ssr;
  logic [1:0]  dout;

  modport master (output addr, output di, output we, output en, output ssr,
                  input  dout);
  modport slave  (input  addr, input  di, input  we, input  en, input  ssr,
                  output dout);
endinterface

// File: rtl/ramb16_s2_s2.sv
// ---------------------------------------------------------------------------
// ramb16_s2_s2
// True dual-port 8192 x 2-bit synchronous block RAM. Each port has a
// registered output. Both ports share one clock.
//   clk    : rising-edge clock for both ports
//   rst    : asynchronous active-high reset. It loads INIT_A / INIT_B into
//            the output registers and blocks writes while high. It never
//            touches the memory contents.
//   port_a : access port A (ramb16_s2_s2_if.slave)
//   port_b : access port B (ramb16_s2_s2_if.slave)
// WRITE_MODE_x selects what a port's output register shows on a write:
// "WRITE_FIRST", "READ_FIRST" or "NO_CHANGE".
// ---------------------------------------------------------------------------
module ramb16_s2_s2 #(
  parameter logic [1:0] INIT_A       = 2'b00,
  parameter logic [1:0] INIT_B       = 2'b00,
  parameter logic [1:0] SRVAL_A      = 2'b00,
  parameter logic [1:0] SRVAL_B      = 2'b00,
  parameter string      WRITE_MODE_A = "WRITE_FIRST",
  parameter string      WRITE_MODE_B = "WRITE_FIRST"
) (
  input  logic            clk,
  input  logic            rst,
  ramb16_s2_s2_if.slave   port_a,
  ramb16_s2_s2_if.slave   port_b
);

  localparam logic [1:0] MODE_WF = 2'd0;
  localparam logic [1:0] MODE_RF = 2'd1;
  localparam logic [1:0] MODE_NC = 2'd2;

  localparam logic [1:0] MODE_A = (WRITE_MODE_A == "READ_FIRST") ? MODE_RF :
                                  (WRITE_MODE_A == "NO_CHANGE")  ? MODE_NC :
                                                                   MODE_WF;
  localparam logic [1:0] MODE_B = (WRITE_MODE_B == "READ_FIRST") ? MODE_RF :
                                  (WRITE_MODE_B == "NO_CHANGE")  ? MODE_NC :
                                                                   MODE_WF;

  logic [1:0] mem [8192];
  logic [1:0] doa_p1;
  logic [1:0] dob_p1;

  // Next value of an enabled port's output register. SSR wins over the
  // write mode. The current value is passed in so NO_CHANGE can hold it.
  function automatic logic [1:0] port_next(
    input logic [1:0] mode,
    input logic       ssr,
    input logic       we,
    input logic [1:0] srval,
    input logic [1:0] di,
    input logic [1:0] rd,
    input logic [1:0] cur
  );
    logic [1:0] nxt;
    if (ssr)
      nxt = srval;
    else if (!we)
      nxt = rd;
    else begin
      case (mode)
        MODE_WF: nxt = di;
        MODE_RF: nxt = rd;
        default: nxt = cur;
      endcase
    end
    return nxt;
  endfunction

  // Stage p0 -> memory: writes commit on the edge and are blocked while
  // rst is high. Port B is written first so that port A's later
  // assignment wins an address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (port_b.en && port_b.we)
        mem[port_b.addr] <= port_b.di;
      if (port_a.en && port_a.we)
        mem[port_a.addr] <= port_a.di;
    end
  end

  // Stage p0 -> p1: output registers. mem[] here is the pre-edge content,
  // so READ_FIRST and a cross-port reader both see the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      doa_p1 <= INIT_A;
    else if (port_a.en)
      doa_p1 <= port_next(MODE_A, port_a.ssr, port_a.we, SRVAL_A,
                          port_a.di, mem[port_a.addr], doa_p1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dob_p1 <= INIT_B;
    else if (port_b.en)
      dob_p1 <= port_next(MODE_B, port_b.ssr, port_b.we, SRVAL_B,
                          port_b.di, mem[port_b.addr], dob_p1);
  end

  assign port_a.dout = doa_p1;
  assign port_b.dout = dob_p1;

endmodule

// File: tb/tb_ramb16_s2_s2.sv
// ---------------------------------------------------------------------------
// tb_ramb16_s2_s2
// Two RAM instances are driven with identical stimulus. They use different
// write modes and INIT/SRVAL values:
//   dut0: A WRITE_FIRST, B READ_FIRST
//   dut1: A READ_FIRST,  B NO_CHANGE
// A word-level model predicts every output register value for each edge.
// The predictions are queued. A monitor compares them after the edge.
// ---------------------------------------------------------------------------
module tb_ramb16_s2_s2;

  logic clk;
  logic rst;

  ramb16_s2_s2_if pa0 ();
  ramb16_s2_s2_if pb0 ();
  ramb16_s2_s2_if pa1 ();
  ramb16_s2_s2_if pb1 ();

  ramb16_s2_s2 #(
    .INIT_A(2'b01), .INIT_B(2'b10), .SRVAL_A(2'b10), .SRVAL_B(2'b01),
    .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("READ_FIRST")
  ) dut0 (.clk(clk), .rst(rst), .port_a(pa0.slave), .port_b(pb0.slave));

  ramb16_s2_s2 #(
    .INIT_A(2'b11), .INIT_B(2'b00), .SRVAL_A(2'b10), .SRVAL_B(2'b11),
    .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("NO_CHANGE")
  ) dut1 (.clk(clk), .rst(rst), .port_a(pa1.slave), .port_b(pb1.slave));

  typedef struct {
    int         dut;
    int         port;
    logic [1:0] val;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  // Reference state: memory words and the expected output registers.
  logic [1:0] mmem [8192];
  logic [1:0] mout [2][2];

  // Current per-port request (applied to both DUTs).
  logic        a_en, a_we, a_ssr, b_en, b_we, b_ssr;
  logic [12:0] a_addr, b_addr;
  logic [1:0]  a_di, b_di;

  // 0 = WRITE_FIRST, 1 = READ_FIRST, 2 = NO_CHANGE
  function automatic int mode_of(int d, int p);
    if (d == 0) return (p == 0) ? 0 : 1;
    return (p == 0) ? 1 : 2;
  endfunction

  function automatic logic [1:0] init_of(int d, int p);
    if (d == 0) return (p == 0) ? 2'b01 : 2'b10;
    return (p == 0) ? 2'b11 : 2'b00;
  endfunction

  function automatic logic [1:0] srv_of(int d, int p);
    if (d == 0) return (p == 0) ? 2'b10 : 2'b01;
    return (p == 0) ? 2'b10 : 2'b11;
  endfunction

  function automatic logic [1:0] get_do(int d, int p);
    if (d == 0 && p == 0) return pa0.dout;
    if (d == 0)           return pb0.dout;
    if (p == 0)           return pa1.dout;
    return pb1.dout;
  endfunction

  task automatic check(input string name, input int d, input int p,
                       input int c, input logic [1:0] act,
                       input logic [1:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s dut%0d port %s cycle %0d: got %b expected %b",
               name, d, (p == 0) ? "A" : "B", c, act, exp);
    else
      n_pass++;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: after each rising edge, compare everything predicted for it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        check("dout", e.dut, e.port, e.cyc, get_do(e.dut, e.port), e.val);
      end
    end
  end

  // Apply the current request, predict the edge outcome, then advance to
  // the next falling edge.
  task automatic tick();
    logic [1:0] rd_a, rd_b, rd, nv, di;
    logic       en, we, ssr;
    pa0.addr = a_addr; pa0.di = a_di; pa0.we = a_we; pa0.en = a_en; pa0.ssr = a_ssr;
    pa1.addr = a_addr; pa1.di = a_di; pa1.we = a_we; pa1.en = a_en; pa1.ssr = a_ssr;
    pb0.addr = b_addr; pb0.di = b_di; pb0.we = b_we; pb0.en = b_en; pb0.ssr = b_ssr;
    pb1.addr = b_addr; pb1.di = b_di; pb1.we = b_we; pb1.en = b_en; pb1.ssr = b_ssr;
    rd_a = mmem[a_addr];
    rd_b = mmem[b_addr];
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        en  = (p == 0) ? a_en  : b_en;
        we  = (p == 0) ? a_we  : b_we;
        ssr = (p == 0) ? a_ssr : b_ssr;
        di  = (p == 0) ? a_di  : b_di;
        rd  = (p == 0) ? rd_a  : rd_b;
        if (rst)          nv = init_of(d, p);
        else if (!en)     nv = mout[d][p];
        else if (ssr)     nv = srv_of(d, p);
        else if (!we)     nv = rd;
        else if (mode_of(d, p) == 0) nv = di;
        else if (mode_of(d, p) == 1) nv = rd;
        else              nv = mout[d][p];
        mout[d][p] = nv;
        q.push_back('{d, p, nv, cyc});
      end
    end
    if (!rst) begin
      if (b_en && b_we) mmem[b_addr] = b_di;
      if (a_en && a_we) mmem[a_addr] = a_di;   // A wins a collision
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic ab(input logic ae, input logic aw, input logic as,
                    input logic [12:0] aa, input logic [1:0] ad,
                    input logic be, input logic bw, input logic bs,
                    input logic [12:0] ba, input logic [1:0] bd);
    a_en = ae; a_we = aw; a_ssr = as; a_addr = aa; a_di = ad;
    b_en = be; b_we = bw; b_ssr = bs; b_addr = ba; b_di = bd;
    tick();
  endtask

  task automatic check_init_now();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        check("async_rst", d, p, cyc, get_do(d, p), init_of(d, p));
        mout[d][p] = init_of(d, p);
      end
  endtask

  initial begin
    logic [12:0] ra, rb;
    for (int i = 0; i < 8192; i++) mmem[i] = 2'b00;
    rst = 1'b0;
    a_en = 0; a_we = 0; a_ssr = 0; a_addr = 0; a_di = 0;
    b_en = 0; b_we = 0; b_ssr = 0; b_addr = 0; b_di = 0;
    pa0.en = 0; pa0.we = 0; pa0.ssr = 0; pa0.addr = 0; pa0.di = 0;
    pa1.en = 0; pa1.we = 0; pa1.ssr = 0; pa1.addr = 0; pa1.di = 0;
    pb0.en = 0; pb0.we = 0; pb0.ssr = 0; pb0.addr = 0; pb0.di = 0;
    pb1.en = 0; pb1.we = 0; pb1.ssr = 0; pb1.addr = 0; pb1.di = 0;

    // Reset before any clock edge: INIT values appear immediately.
    #1 rst = 1'b1;
    #1 check_init_now();
    @(negedge clk);
    // A write request while reset is held must be blocked.
    ab(1, 1, 0, 13'd0, 2'd3,  1, 1, 0, 13'd1, 2'd2);
    rst = 1'b0;

    // Basic reads and writes, including address 8191.
    ab(1, 0, 0, 13'd0, 2'd0,     0, 0, 0, 13'd0, 2'd0);
    ab(1, 0, 0, 13'd1, 2'd0,     1, 0, 0, 13'd0, 2'd0);
    ab(1, 1, 0, 13'd8191, 2'd3,  0, 0, 0, 13'd0, 2'd0);
    ab(0, 0, 0, 13'd0, 2'd0,     1, 0, 0, 13'd8191, 2'd0);

    // Write modes on port A, then on port B, at address 5.
    ab(1, 1, 0, 13'd5, 2'd1,  0, 0, 0, 13'd0, 2'd0);
    ab(1, 1, 0, 13'd5, 2'd2,  0, 0, 0, 13'd0, 2'd0);
    ab(1, 0, 0, 13'd5, 2'd0,  0, 0, 0, 13'd0, 2'd0);
    ab(0, 0, 0, 13'd0, 2'd0,  1, 1, 0, 13'd5, 2'd1);
    ab(0, 0, 0, 13'd0, 2'd0,  1, 1, 0, 13'd5, 2'd2);
    ab(0, 0, 0, 13'd0, 2'd0,  1, 0, 0, 13'd5, 2'd0);

    // SSR together with a write, then read back the written word.
    ab(1, 1, 1, 13'd9, 2'd3,  1, 0, 1, 13'd9, 2'd0);
    ab(1, 0, 0, 13'd9, 2'd0,  1, 0, 0, 13'd9, 2'd0);

    // Disabled port ignores WE and SSR.
    ab(1, 0, 0, 13'd4, 2'd0,  0, 0, 0, 13'd0, 2'd0);
    ab(0, 1, 1, 13'd4, 2'd3,  0, 1, 1, 13'd4, 2'd2);
    ab(1, 0, 0, 13'd4, 2'd0,  1, 0, 0, 13'd4, 2'd0);

    // Collisions on address 7.
    ab(1, 1, 0, 13'd7, 2'd1,  1, 1, 0, 13'd7, 2'd2);
    ab(1, 0, 0, 13'd7, 2'd0,  1, 0, 0, 13'd7, 2'd0);
    ab(1, 1, 0, 13'd7, 2'd3,  1, 0, 0, 13'd7, 2'd0);
    ab(0, 0, 0, 13'd0, 2'd0,  1, 0, 0, 13'd7, 2'd0);
    ab(1, 0, 0, 13'd8, 2'd0,  1, 1, 0, 13'd8, 2'd2);
    ab(1, 0, 0, 13'd8, 2'd0,  1, 0, 0, 13'd8, 2'd0);

    // Mid-run reset: a committed write survives, writes under reset do not.
    ab(1, 1, 0, 13'd20, 2'd2,  1, 1, 0, 13'd22, 2'd1);
    #2 rst = 1'b1;
    #1 check_init_now();
    @(negedge clk);
    ab(1, 1, 0, 13'd21, 2'd3,  1, 1, 0, 13'd20, 2'd1);
    ab(0, 0, 0, 13'd0, 2'd0,   0, 0, 0, 13'd0, 2'd0);
    rst = 1'b0;
    ab(1, 0, 0, 13'd20, 2'd0,  1, 0, 0, 13'd21, 2'd0);
    ab(1, 0, 0, 13'd22, 2'd0,  1, 0, 0, 13'd20, 2'd0);

    // Randomized traffic over a small address window plus the top word.
    for (int i = 0; i < 1500; i++) begin
      ra = ($urandom_range(0, 5) == 0) ? 13'd8191 : 13'($urandom_range(0, 15));
      rb = ($urandom_range(0, 5) == 0) ? 13'd8191 : 13'($urandom_range(0, 15));
      ab(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 9) == 0), ra, 2'($urandom_range(0, 3)),
         1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 9) == 0), rb, 2'($urandom_range(0, 3)));
    end

    // Final read sweep of the exercised window.
    for (int i = 0; i < 17; i++) begin
      ra = (i == 16) ? 13'd8191 : 13'(i);
      ab(1, 0, 0, ra, 2'd0,  1, 0, 0, ra, 2'd0);
    end

    ab(0, 0, 0, 13'd0, 2'd0,  0, 0, 0, 13'd0, 2'd0);
    @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
